// File: rtl/io_pkg.sv
// Shared constants and types for the I/O port stage.
// Holds the default data width, control-unit decode values and output FSM states.
package io_pkg;

  localparam int IO_DATA_W = 16;

  localparam logic [3:0] OPC_IO      = 4'b1100;
  localparam logic [2:0] FUNK_IN     = 3'd1;
  localparam logic [1:0] MEMTOREG_IO = 2'b10;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_FULL = 1'b1
  } outState_e;

endpackage

// File: rtl/io_port_unit_if.sv
// External input/output handshake bundle for io_port_unit.
// master: the port unit side; slave: the external producer/consumer side.
interface io_port_unit_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] ext_in_data;
  logic              ext_in_valid;
  logic              ext_in_ready;
  logic [DATA_W-1:0] ext_out_data;
  logic              ext_out_valid;
  logic              ext_out_ready;

  modport master (
    input  ext_in_data,
    input  ext_in_valid,
    output ext_in_ready,
    output ext_out_data,
    output ext_out_valid,
    input  ext_out_ready
  );

  modport slave (
    output ext_in_data,
    output ext_in_valid,
    input  ext_in_ready,
    input  ext_out_data,
    input  ext_out_valid,
    output ext_out_ready
  );

endinterface

// File: rtl/io_in_fifo.sv
// Synchronous input FIFO: push/pop, occupancy count, combinational head word.
// Ports: CLK, Reset, push, pop, wrData in; head, count, full, empty out.
module io_in_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic              doPush;
  logic              doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  // No bypass: an empty FIFO reads as zero.
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      unique case (1'b1)
        (doPush && !doPop): count <= count + CW'(1);
        (doPop && !doPush): count <= count - CW'(1);
        default:            count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/io_port_unit.sv
// I/O stage behind the control unit's in/out states: input FIFO plus output register.
// Ports: CLK, Reset, InputRead, OutputWrite, WriteData, ReadData, io_stall, ext, in_count, in_underflow.
module io_port_unit
  import io_pkg::*;
#(
  parameter  int DATA_W   = IO_DATA_W,
  parameter  int IN_DEPTH = 4,
  localparam int CW       = $clog2(IN_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InputRead,
  input  logic              OutputWrite,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              io_stall,
  io_port_unit_if.master    ext,
  output logic [CW-1:0]     in_count,
  output logic              in_underflow
);

  outState_e         state;
  outState_e         stateNxt;
  logic [DATA_W-1:0] outReg;
  logic              load;
  logic              inFull;
  logic              inEmpty;
  logic              outValid;

  io_in_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (IN_DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .Reset  (Reset),
    .push   (ext.ext_in_valid),
    .pop    (InputRead),
    .wrData (ext.ext_in_data),
    .head   (ReadData),
    .count  (in_count),
    .full   (inFull),
    .empty  (inEmpty)
  );

  assign ext.ext_in_ready  = !inFull;
  assign outValid          = (state == OUT_FULL);
  assign ext.ext_out_valid = outValid;
  assign ext.ext_out_data  = outReg;

  assign io_stall = (InputRead && inEmpty)
                 || (OutputWrite && outValid && !ext.ext_out_ready);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= OUT_IDLE;
      outReg       <= '0;
      in_underflow <= 1'b0;
    end else begin
      state <= stateNxt;
      if (load) outReg <= WriteData;
      if (InputRead && inEmpty) in_underflow <= 1'b1;
    end
  end

  // A write into a full, unconsumed register is dropped; control retries.
  always_comb begin
    stateNxt = state;
    load     = 1'b0;
    unique case (state)
      OUT_IDLE: begin
        if (OutputWrite) begin
          load     = 1'b1;
          stateNxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (ext.ext_out_ready) begin
          if (OutputWrite) load = 1'b1;
          else stateNxt = OUT_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed self-checking bench for io_port_unit.
// Inputs change 1ns after the rising edge; outputs are checked 3ns after it.
module tb_io_port_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        InputRead;
  logic        OutputWrite;
  logic [15:0] WriteData;
  logic [15:0] ReadData;
  logic        io_stall;
  logic [2:0]  in_count;
  logic        in_underflow;
  int          nCmp = 0;
  int          nErr = 0;

  io_port_unit_if #(.DATA_W(16)) ext ();

  io_port_unit #(.DATA_W(16), .IN_DEPTH(4)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .InputRead    (InputRead),
    .OutputWrite  (OutputWrite),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .io_stall     (io_stall),
    .ext          (ext),
    .in_count     (in_count),
    .in_underflow (in_underflow)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    InputRead         = 1'b0;
    OutputWrite       = 1'b0;
    WriteData         = '0;
    ext.ext_in_valid  = 1'b0;
    ext.ext_in_data   = '0;
    ext.ext_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd0) begin nErr++; $display("FAIL reset_count got %0d want 0", in_count); end
    nCmp++; if (ext.ext_out_valid !== 1'b0) begin nErr++; $display("FAIL reset_oval got %b want 0", ext.ext_out_valid); end
    nCmp++; if (ext.ext_out_data !== 16'h0) begin nErr++; $display("FAIL reset_odata got %h want 0000", ext.ext_out_data); end
    nCmp++; if (in_underflow !== 1'b0) begin nErr++; $display("FAIL reset_uflow got %b want 0", in_underflow); end
    nCmp++; if (ext.ext_in_ready !== 1'b1) begin nErr++; $display("FAIL reset_iready got %b want 1", ext.ext_in_ready); end
    nCmp++; if (ReadData !== 16'h0) begin nErr++; $display("FAIL reset_rdata got %h want 0000", ReadData); end
    nCmp++; if (io_stall !== 1'b0) begin nErr++; $display("FAIL reset_stall got %b want 0", io_stall); end
    tick();
  endtask

  task automatic test_fifo_basic();
    ext.ext_in_valid = 1'b1;
    ext.ext_in_data  = 16'h00A1;
    tick();
    ext.ext_in_data  = 16'h00B2;
    tick();
    ext.ext_in_valid = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd2) begin nErr++; $display("FAIL basic_cnt2 got %0d want 2", in_count); end
    InputRead = 1'b1;
    settle();
    nCmp++; if (ReadData !== 16'h00A1) begin nErr++; $display("FAIL basic_rd1 got %h want 00a1", ReadData); end
    nCmp++; if (io_stall !== 1'b0) begin nErr++; $display("FAIL basic_stall1 got %b want 0", io_stall); end
    tick();
    settle();
    nCmp++; if (in_count !== 3'd1) begin nErr++; $display("FAIL basic_cnt1 got %0d want 1", in_count); end
    nCmp++; if (ReadData !== 16'h00B2) begin nErr++; $display("FAIL basic_rd2 got %h want 00b2", ReadData); end
    nCmp++; if (io_stall !== 1'b0) begin nErr++; $display("FAIL basic_stall2 got %b want 0", io_stall); end
    tick();
    InputRead = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd0) begin nErr++; $display("FAIL basic_cnt0 got %0d want 0", in_count); end
    tick();
  endtask

  task automatic test_full();
    ext.ext_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext.ext_in_data = 16'h0011 + 16'(i);
      tick();
    end
    settle();
    nCmp++; if (in_count !== 3'd4) begin nErr++; $display("FAIL full_cnt got %0d want 4", in_count); end
    nCmp++; if (ext.ext_in_ready !== 1'b0) begin nErr++; $display("FAIL full_ready got %b want 0", ext.ext_in_ready); end
    ext.ext_in_data = 16'h0015;
    tick();
    settle();
    nCmp++; if (in_count !== 3'd4) begin nErr++; $display("FAIL full_nopush got %0d want 4", in_count); end
    InputRead = 1'b1;
    settle();
    nCmp++; if (ReadData !== 16'h0011) begin nErr++; $display("FAIL full_head got %h want 0011", ReadData); end
    nCmp++; if (ext.ext_in_ready !== 1'b0) begin nErr++; $display("FAIL full_poprdy got %b want 0", ext.ext_in_ready); end
    tick();
    InputRead        = 1'b0;
    ext.ext_in_valid = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd3) begin nErr++; $display("FAIL full_cnt3 got %0d want 3", in_count); end
    nCmp++; if (ext.ext_in_ready !== 1'b1) begin nErr++; $display("FAIL full_rdy1 got %b want 1", ext.ext_in_ready); end
    InputRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      nCmp++; if (ReadData !== 16'h0012 + 16'(i)) begin nErr++; $display("FAIL full_drain%0d got %h want %h", i, ReadData, 16'h0012 + 16'(i)); end
      tick();
    end
    InputRead = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd0) begin nErr++; $display("FAIL full_empty got %0d want 0", in_count); end
    tick();
  endtask

  task automatic test_underflow();
    InputRead = 1'b1;
    settle();
    nCmp++; if (io_stall !== 1'b1) begin nErr++; $display("FAIL uf_stall got %b want 1", io_stall); end
    nCmp++; if (ReadData !== 16'h0) begin nErr++; $display("FAIL uf_rdata got %h want 0000", ReadData); end
    tick();
    InputRead = 1'b0;
    settle();
    nCmp++; if (in_underflow !== 1'b1) begin nErr++; $display("FAIL uf_sticky got %b want 1", in_underflow); end
    ext.ext_in_valid = 1'b1;
    ext.ext_in_data  = 16'h0077;
    tick();
    ext.ext_in_valid = 1'b0;
    InputRead        = 1'b1;
    settle();
    nCmp++; if (ReadData !== 16'h0077) begin nErr++; $display("FAIL uf_read got %h want 0077", ReadData); end
    nCmp++; if (io_stall !== 1'b0) begin nErr++; $display("FAIL uf_okstall got %b want 0", io_stall); end
    tick();
    InputRead = 1'b0;
    settle();
    nCmp++; if (in_underflow !== 1'b1) begin nErr++; $display("FAIL uf_hold got %b want 1", in_underflow); end
    ext.ext_in_valid = 1'b1;
    ext.ext_in_data  = 16'h0055;
    InputRead        = 1'b1;
    settle();
    nCmp++; if (io_stall !== 1'b1) begin nErr++; $display("FAIL uf_nobyp_stall got %b want 1", io_stall); end
    nCmp++; if (ReadData !== 16'h0) begin nErr++; $display("FAIL uf_nobyp_rd got %h want 0000", ReadData); end
    tick();
    ext.ext_in_valid = 1'b0;
    InputRead        = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd1) begin nErr++; $display("FAIL uf_stored_cnt got %0d want 1", in_count); end
    nCmp++; if (ReadData !== 16'h0055) begin nErr++; $display("FAIL uf_stored got %h want 0055", ReadData); end
    InputRead = 1'b1;
    tick();
    InputRead = 1'b0;
    tick();
  endtask

  task automatic test_output();
    OutputWrite = 1'b1;
    WriteData   = 16'h1234;
    settle();
    nCmp++; if (io_stall !== 1'b0) begin nErr++; $display("FAIL out_stall0 got %b want 0", io_stall); end
    tick();
    OutputWrite = 1'b0;
    settle();
    nCmp++; if (ext.ext_out_valid !== 1'b1) begin nErr++; $display("FAIL out_valid got %b want 1", ext.ext_out_valid); end
    nCmp++; if (ext.ext_out_data !== 16'h1234) begin nErr++; $display("FAIL out_data1 got %h want 1234", ext.ext_out_data); end
    OutputWrite = 1'b1;
    WriteData   = 16'h5678;
    settle();
    nCmp++; if (io_stall !== 1'b1) begin nErr++; $display("FAIL out_stall1 got %b want 1", io_stall); end
    tick();
    settle();
    nCmp++; if (ext.ext_out_data !== 16'h1234) begin nErr++; $display("FAIL out_hold got %h want 1234", ext.ext_out_data); end
    ext.ext_out_ready = 1'b1;
    settle();
    nCmp++; if (io_stall !== 1'b0) begin nErr++; $display("FAIL out_stall2 got %b want 0", io_stall); end
    tick();
    OutputWrite       = 1'b0;
    ext.ext_out_ready = 1'b0;
    settle();
    nCmp++; if (ext.ext_out_data !== 16'h5678) begin nErr++; $display("FAIL out_data2 got %h want 5678", ext.ext_out_data); end
    nCmp++; if (ext.ext_out_valid !== 1'b1) begin nErr++; $display("FAIL out_valid2 got %b want 1", ext.ext_out_valid); end
    ext.ext_out_ready = 1'b1;
    tick();
    ext.ext_out_ready = 1'b0;
    settle();
    nCmp++; if (ext.ext_out_valid !== 1'b0) begin nErr++; $display("FAIL out_drain got %b want 0", ext.ext_out_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    InputRead = 1'b1;
    tick();
    InputRead        = 1'b0;
    ext.ext_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ext.ext_in_data = 16'h0031 + 16'(i);
      tick();
    end
    ext.ext_in_valid = 1'b0;
    OutputWrite      = 1'b1;
    WriteData        = 16'hBEEF;
    tick();
    OutputWrite = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd3) begin nErr++; $display("FAIL rm_pre_cnt got %0d want 3", in_count); end
    nCmp++; if (ext.ext_out_data !== 16'hBEEF) begin nErr++; $display("FAIL rm_pre_out got %h want beef", ext.ext_out_data); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    settle();
    nCmp++; if (in_count !== 3'd0) begin nErr++; $display("FAIL rm_cnt got %0d want 0", in_count); end
    nCmp++; if (ext.ext_out_valid !== 1'b0) begin nErr++; $display("FAIL rm_oval got %b want 0", ext.ext_out_valid); end
    nCmp++; if (ext.ext_in_ready !== 1'b1) begin nErr++; $display("FAIL rm_irdy got %b want 1", ext.ext_in_ready); end
    nCmp++; if (in_underflow !== 1'b0) begin nErr++; $display("FAIL rm_uflow got %b want 0", in_underflow); end
    tick();
  endtask

  task automatic test_back_to_back();
    ext.ext_in_valid = 1'b1;
    ext.ext_in_data  = 16'd1;
    tick();
    InputRead = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      ext.ext_in_data = 16'(k + 1);
      settle();
      nCmp++; if (ReadData !== 16'(k)) begin nErr++; $display("FAIL b2b_rd%0d got %0d want %0d", k, ReadData, k); end
      nCmp++; if (in_count !== 3'd1) begin nErr++; $display("FAIL b2b_cnt%0d got %0d want 1", k, in_count); end
      tick();
    end
    InputRead        = 1'b0;
    ext.ext_in_valid = 1'b0;
    settle();
    nCmp++; if (ReadData !== 16'd11) begin nErr++; $display("FAIL b2b_last got %0d want 11", ReadData); end
    nCmp++; if (io_stall !== 1'b0) begin nErr++; $display("FAIL b2b_stall got %b want 0", io_stall); end
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fifo_basic();
    test_full();
    test_underflow();
    test_output();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Memory-mapped-free I/O stage that sits directly downstream of the multicycle control unit's in/out states.
- Consumes OutputWrite and the register value for the "out" instruction, opcode 4'b1100, funk != 1, and drives it to an external sink with valid/ready.
- Buffers external input words in a small FIFO and presents the head word on ReadData for the "in" instruction (opcode 4'b1100, funk == 1, MemtoReg = 2'b10 path).
- Raises io_stall when the requested transfer cannot complete, so the control unit holds its in/out state.

Parameters:
- DATA_W, 16, datapath word width.
- IN_DEPTH, 4, input FIFO entries; power of two, 2 or more.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InputRead  input  1  control is in the "in" state; pop FIFO head into register file this cycle.
- OutputWrite  input  1  control is in the "out" state; load WriteData into output register.
- WriteData  input  DATA_W  register-file value to output.
- ReadData  output  DATA_W  FIFO head word; feeds the MemtoReg=2'b10 mux input.
- io_stall  output  1  requested InputRead/OutputWrite cannot complete this cycle.
- ext_in_data  input  DATA_W  external input word.
- ext_in_valid  input  1  external input word present.
- ext_in_ready  output  1  FIFO can accept a word.
- ext_out_data  output  DATA_W  output register contents.
- ext_out_valid  output  1  output register holds an unconsumed word.
- ext_out_ready  input  1  external sink accepts word.
- in_count  output  $clog2(IN_DEPTH+1)  current FIFO occupancy.
- in_underflow  output  1  sticky: InputRead seen while FIFO empty.

Behaviour:
- Reset (synchronous, sampled on CLK rising edge while Reset=1):
  - FIFO pointers and in_count = 0.
  - ext_out_valid = 0, ext_out_data = 0, in_underflow = 0.
  - Reset mid-transfer discards all buffered input and any pending output word.
- Input FIFO:
  - Push when ext_in_valid && ext_in_ready; ext_in_ready = (in_count != IN_DEPTH), combinational from registered count only.
  - ReadData = head entry, combinational, 0 when empty.
  - Pop at the CLK edge when InputRead && in_count != 0. The data is visible the same cycle the control unit's RegWrite captures it, so latency is zero from InputRead to ReadData.
  - Pointers wrap modulo IN_DEPTH.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, ext_in_ready=0 even if a pop occurs that cycle; there is no same-cycle refill.
  - When empty, push and InputRead in the same cycle: no bypass. io_stall=1, ReadData=0, in_underflow set, pushed word stored.
- Output register FSM with two states:
  - OUT_IDLE: ext_out_valid=0. OutputWrite loads WriteData, goes to OUT_FULL, io_stall=0.
  - OUT_FULL: ext_out_valid=1, ext_out_data stable.
    - ext_out_ready && !OutputWrite: go to OUT_IDLE.
    - ext_out_ready && OutputWrite: reload WriteData, stay in OUT_FULL, io_stall=0.
    - !ext_out_ready && OutputWrite: io_stall=1, write dropped, register unchanged. Control must re-assert OutputWrite.
- io_stall = (InputRead && in_count==0) || (OutputWrite && ext_out_valid && !ext_out_ready). Combinational.
- InputRead and OutputWrite together are illegal from the control unit. If both occur, each is handled independently per the rules above.
- in_underflow clears only on Reset.

Decomposition:
- Shared package io_pkg holds:
  - DATA_W default.
  - OPC_IO = 4'b1100.
  - FUNK_IN = 3'd1.
  - MEMTOREG_IO = 2'b10.
  - Output FSM state encoding: OUT_IDLE=1'b0, OUT_FULL=1'b1.
- One sub-module, io_in_fifo: parameterised synchronous FIFO with push/pop/count/head. The output FSM and stall logic stay in io_port_unit.

Test Plan:
- Reset, then push 16'h00A1, 16'h00B2 via ext_in_valid. Two InputRead cycles → ReadData 16'h00A1 then 16'h00B2; in_count 2→1→0; io_stall=0.
- Push 4 words with no reads → ext_in_ready=0 after 4th, in_count=4. Hold ext_in_valid with a 5th word → not accepted. One InputRead → pop; ext_in_ready=1 next cycle.
- InputRead with empty FIFO → io_stall=1, ReadData=0, in_underflow=1 and remains 1 after a later successful read.
- OutputWrite with WriteData=16'h1234 and ext_out_ready=0 → next cycle ext_out_valid=1, data 16'h1234. Second OutputWrite with 16'h5678 while ready=0 → io_stall=1, data stays 16'h1234. Raise ready with OutputWrite held → data 16'h5678, io_stall=0.
- Push 3 words, load output 16'hBEEF, assert Reset one cycle → in_count=0, ext_out_valid=0, ext_in_ready=1, in_underflow=0.
- Continuous push and pop each cycle for 10 cycles with incrementing data 1..10 → pointer wrap, ReadData sequence 1..10 in order, in_count constant.
